// File: rtl/shared_alu_pkg.sv
// Shared definitions for the arbitrated two-stage ALU: opcode width and opcode enum.
package shared_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/shared_alu_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last+1 with wrap; the
// last pointer only moves when the grant is actually consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IDW = $clog2(N);

  logic [IDW-1:0] last_q;
  logic [IDW-1:0] last_d;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_q) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    last_d = advance ? grant_idx : last_q;
  end

  // Reset to N-1 so the first search starts at requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IDW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shared_alu_arb.sv
// N requesters share one ALU through a round-robin arbiter feeding a
// two-stage pipeline (S1 operands, S2 result) with valid/ready backpressure.
module shared_alu_arb
  import shared_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [OP_W*N-1:0]  req_op,
  input  logic [WIDTH*N-1:0] req_left,
  input  logic [WIDTH*N-1:0] req_right,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [WIDTH-1:0]   resp_data
);

  logic [N-1:0]     grant;
  logic             accept;
  logic             s1_can_load;
  logic             s2_can_load;

  logic             s1_valid_q, s1_valid_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_left_q, s1_left_d;
  logic [WIDTH-1:0] s1_right_q, s1_right_d;
  logic [WIDTH-1:0] alu_result;

  logic             s2_valid_q, s2_valid_d;
  logic [IDW-1:0]   s2_id_q, s2_id_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;

  rr_arbiter #(.N(N)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is gated by reset so nothing is accepted while reset_n is low.
  always_comb begin
    s2_can_load = !s2_valid_q || resp_ready;
    s1_can_load = !s1_valid_q || s2_can_load;
    req_ready   = (reset_n && s1_can_load) ? grant : '0;
    accept      = |req_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    s1_left_d  = s1_left_q;
    s1_right_d = s1_right_q;
    if (s1_can_load) begin
      s1_valid_d = accept;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        s1_id_d    = IDW'(i);
        s1_op_d    = alu_op_e'(req_op[OP_W*i +: OP_W]);
        s1_left_d  = req_left[WIDTH*i +: WIDTH];
        s1_right_d = req_right[WIDTH*i +: WIDTH];
      end
    end
  end

  // Logical shifts by the full right operand already give 0 once it reaches WIDTH.
  always_comb begin
    alu_result = '0;
    case (s1_op_q)
      OP_ADD:  alu_result = s1_left_q + s1_right_q;
      OP_SUB:  alu_result = s1_left_q - s1_right_q;
      OP_MUL:  alu_result = s1_left_q * s1_right_q;
      OP_AND:  alu_result = s1_left_q & s1_right_q;
      OP_OR:   alu_result = s1_left_q | s1_right_q;
      OP_XOR:  alu_result = s1_left_q ^ s1_right_q;
      OP_SHL:  alu_result = s1_left_q << s1_right_q;
      OP_SHR:  alu_result = s1_left_q >> s1_right_q;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d   = s1_id_q;
        s2_data_d = alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    s1_id_q    <= s1_id_d;
    s1_op_q    <= s1_op_d;
    s1_left_q  <= s1_left_d;
    s1_right_q <= s1_right_d;
    s2_id_q    <= s2_id_d;
    s2_data_q  <= s2_data_d;
  end

  assign resp_valid = s2_valid_q;
  assign resp_id    = s2_id_q;
  assign resp_data  = s2_data_q;

endmodule

// File: tb/tb_shared_alu_arb.sv
// Self-checking bench for shared_alu_arb: directed vectors and sequences plus
// randomized traffic scored against an in-order queue model of the arbiter.
module tb_shared_alu_arb;
  import shared_alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic               clk;
  logic               reset_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [3*N-1:0]     req_op;
  logic [WIDTH*N-1:0] req_left;
  logic [WIDTH*N-1:0] req_right;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [WIDTH-1:0]   resp_data;

  shared_alu_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_left   (req_left),
    .req_right  (req_right),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
  } item_t;

  typedef struct {
    alu_op_e op;
    int      left;
    int      right;
    int      expected;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];
  int    model_last;
  int    model_grant;
  int    dut_grant;
  bit    hold_pending;
  bit    resp_seen;
  int    seen_id;
  int    seen_data;
  int    seen_valid;
  int    resp_total;
  int    dut_accepts;
  vec_t  vecs[12];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (b >= WIDTH) ? 0 : (a << b);
      default: r = (b >= WIDTH) ? 0 : (a >> b);
    endcase
    return r & ((1 << WIDTH) - 1);
  endfunction

  function automatic int pick_grant(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(model_last + k) % N]) return (model_last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input alu_op_e op, input int l, input int r);
    req_op[3*i +: 3]           = op;
    req_left[WIDTH*i +: WIDTH]  = WIDTH'(l);
    req_right[WIDTH*i +: WIDTH] = WIDTH'(r);
  endtask

  // One clock cycle: sample at the falling edge, score, then advance the model.
  task automatic step();
    int    ready_exp;
    bit    can_accept;
    item_t it;
    @(negedge clk);
    can_accept  = (exp_q.size() < 2) || resp_ready;
    model_grant = pick_grant(req_valid);
    ready_exp   = (can_accept && model_grant >= 0) ? (1 << model_grant) : 0;
    check("req_ready", int'(req_ready), ready_exp);
    dut_grant = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grant = i;
    if (dut_grant >= 0) dut_accepts++;
    seen_valid = int'(resp_valid);
    resp_seen  = 1'b0;
    seen_id    = -1;
    seen_data  = -1;
    if (hold_pending) check("resp_hold_valid", int'(resp_valid), 1);
    hold_pending = 1'b0;
    if (exp_q.size() == 0) begin
      check("resp_valid_idle", int'(resp_valid), 0);
    end else if (resp_valid) begin
      check("resp_id", int'(resp_id), exp_q[0].id);
      check("resp_data", int'(resp_data), exp_q[0].data);
      if (resp_ready) begin
        resp_seen = 1'b1;
        seen_id   = int'(resp_id);
        seen_data = int'(resp_data);
        resp_total++;
        void'(exp_q.pop_front());
      end else begin
        hold_pending = 1'b1;
      end
    end
    if (ready_exp != 0) begin
      it.id   = model_grant;
      it.data = ref_alu(int'(req_op[3*model_grant +: 3]),
                        int'(req_left[WIDTH*model_grant +: WIDTH]),
                        int'(req_right[WIDTH*model_grant +: WIDTH]));
      exp_q.push_back(it);
      model_last = model_grant;
    end else begin
      model_grant = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b1;
    #1;
    check("reset_resp_valid", int'(resp_valid), 0);
    check("reset_req_ready", int'(req_ready), 0);
    exp_q.delete();
    model_last   = N - 1;
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_req_ready", int'(req_ready), 0);
    req_valid = '0;
    reset_n   = 1'b1;
  endtask

  task automatic drain(input string name);
    int budget;
    req_valid  = '0;
    resp_ready = 1'b1;
    budget     = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic apply_stimulus_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_req(i, alu_op_e'($urandom_range(0, 7)), int'($urandom),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : int'($urandom));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{OP_ADD, 5,    7,    12};
    vecs[1]  = '{OP_SUB, 0,    1,    8'hFF};
    vecs[2]  = '{OP_MUL, 16,   16,   8'h00};
    vecs[3]  = '{OP_SHL, 1,    9,    8'h00};
    vecs[4]  = '{OP_SHR, 8'h80, 7,   8'h01};
    vecs[5]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30};
    vecs[6]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF};
    vecs[7]  = '{OP_XOR, 8'hAA, 8'hFF, 8'h55};
    vecs[8]  = '{OP_SHL, 1,    7,    8'h80};
    vecs[9]  = '{OP_SHR, 8'hFF, 8,   8'h00};
    vecs[10] = '{OP_ADD, 8'hFF, 1,   8'h00};
    vecs[11] = '{OP_MUL, 15,   17,   8'hFF};

    reset_n      = 1'b0;
    req_valid    = '0;
    req_op       = '0;
    req_left     = '0;
    req_right    = '0;
    resp_ready   = 1'b1;
    resp_total   = 0;
    dut_accepts  = 0;
    hold_pending = 1'b0;
    model_last   = N - 1;
    @(posedge clk);
    #1;

    // Single ADD right after reset: accepted at once, result two cycles later.
    apply_reset();
    set_req(0, OP_ADD, 5, 7);
    req_valid = 4'b0001;
    step();
    check("first_accept_grant", dut_grant, 0);
    req_valid = '0;
    step();
    check("latency_t1_valid", seen_valid, 0);
    step();
    check("latency_t2_valid", seen_valid, 1);
    check("latency_t2_id", seen_id, 0);
    check("latency_t2_data", seen_data, 12);

    // Table of edge-case arithmetic through requester 0.
    apply_reset();
    for (int v = 0; v < 12; v++) begin
      int budget;
      set_req(0, vecs[v].op, vecs[v].left, vecs[v].right);
      req_valid = 4'b0001;
      step();
      check("vec_accept", dut_grant, 0);
      req_valid = '0;
      budget = 6;
      step();
      while (!resp_seen && budget > 0) begin
        step();
        budget--;
      end
      check("vec_resp_seen", int'(resp_seen), 1);
      check("vec_data", seen_data, vecs[v].expected);
    end

    // All four requesters held valid: strict rotation 0,1,2,3,0,1,2,3.
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 10 * i, i + 1);
    req_valid = 4'b1111;
    resp_total = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_grant", dut_grant, c % N);
    end
    drain("rr_drain");
    check("rr_resp_count", resp_total, 8);

    // Backpressure: only two operations fit while the consumer stalls.
    apply_reset();
    set_req(1, OP_SUB, 100, 3);
    req_valid   = 4'b0010;
    resp_ready  = 1'b0;
    dut_accepts = 0;
    resp_total  = 0;
    for (int c = 0; c < 5; c++) step();
    check("bp_accepts", dut_accepts, 2);
    drain("bp_drain");
    check("bp_resp_count", resp_total, 2);

    // Reset with both stages full drops resp_valid immediately.
    apply_reset();
    set_req(0, OP_XOR, 8'h0F, 8'h01);
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    step();
    step();
    req_valid = '0;
    step();
    check("full_before_reset", seen_valid, 1);
    #2;
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("async_reset_resp_valid", int'(resp_valid), 0);
    check("async_reset_req_ready", int'(req_ready), 0);
    exp_q.delete();
    model_last   = N - 1;
    hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    reset_n    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_reset_no_stale", seen_valid, 0);
    end
    req_valid = 4'b1111;
    step();
    check("post_reset_grant", dut_grant, 0);
    drain("post_reset_drain");

    // Randomized traffic with random backpressure.
    apply_reset();
    apply_stimulus_random(400);
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
